instr_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the cpu fetch port (PC/INSTRUCTION)
//  and the byte-organised instruction memory (1024 x 8). A hit returns the instruction in the same cycle.
//  A miss stalls the cpu via BUSYWAIT and fetches one whole block from memory over a busywait handshake.

---
 rtl/instr_cache.sv | 113 +++++++++++
 tb/tb_instr_cache.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache. Hits answer combinationally in the
// lookup cycle; misses stall the cpu and fill a whole line over a busywait handshake.
module instr_cache #(
    parameter int ADDR_W      = 10,
    parameter int BLOCKS      = 8,
    parameter int BLOCK_WORDS = 4,
    localparam int WSEL_W     = $clog2(BLOCK_WORDS),
    localparam int OFF_BITS   = WSEL_W + 2,
    localparam int IDX_W      = $clog2(BLOCKS),
    localparam int BLK_W      = ADDR_W - OFF_BITS,
    localparam int TAG_W      = BLK_W - IDX_W,
    localparam int LINE_W     = BLOCK_WORDS * 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       PC,
    output logic [31:0]       INSTRUCTION,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic [BLK_W-1:0]  MEM_ADDRESS,
    input  logic [LINE_W-1:0] MEM_READINST,
    input  logic              MEM_BUSYWAIT
);

    typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

    state_t state, state_next;

    logic [BLOCKS-1:0] valid;
    logic [TAG_W-1:0]  tag_arr  [BLOCKS];
    logic [LINE_W-1:0] data_arr [BLOCKS];

    logic [BLK_W-1:0]  addr_q;
    logic              busy_seen;

    logic              in_range;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] word_sel;
    logic              hit;
    logic              lookup_miss;
    logic              fill_done;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [1:0]        unused_pc_bits;

    assign unused_pc_bits = PC[1:0];

    assign in_range    = (PC[31:ADDR_W] == '0);
    assign index       = PC[OFF_BITS +: IDX_W];
    assign tag         = PC[OFF_BITS + IDX_W +: TAG_W];
    assign word_sel    = PC[2 +: WSEL_W];
    assign hit         = in_range && valid[index] && (tag_arr[index] == tag);
    assign lookup_miss = in_range && !hit;

    // The memory's busywait is only trusted after it has been seen high once.
    assign fill_done = (state == S_MEM_READ) && busy_seen && !MEM_BUSYWAIT;
    assign fill_idx  = addr_q[IDX_W-1:0];
    assign fill_tag  = addr_q[BLK_W-1 -: TAG_W];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (lookup_miss) state_next = S_MEM_READ;
            S_MEM_READ: if (fill_done)   state_next = S_UPDATE;
            S_UPDATE:                    state_next = S_IDLE;
            default:                     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        MEM_READ    = (state == S_MEM_READ);
        MEM_ADDRESS = addr_q;
        BUSYWAIT    = RESET && ((state != S_IDLE) || lookup_miss);
        INSTRUCTION = hit ? data_arr[index][word_sel*32 +: 32] : 32'h0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_q    <= '0;
            busy_seen <= 1'b0;
            valid     <= '0;
        end else begin
            if (state == S_IDLE && lookup_miss)
                addr_q <= PC[OFF_BITS +: BLK_W];
            if (state == S_IDLE)
                busy_seen <= 1'b0;
            else if (state == S_MEM_READ && MEM_BUSYWAIT)
                busy_seen <= 1'b1;
            if (fill_done)
                valid[fill_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the valid bits
    // alone decide whether their contents mean anything.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= MEM_READINST;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: stimulus queues expected fetch results,
// a negedge monitor pops and compares them whenever the cache answers.
module tb_instr_cache;

    logic          CLK;
    logic          RESET;
    logic [31:0]   PC;
    logic [31:0]   INSTRUCTION;
    logic          BUSYWAIT;
    logic          MEM_READ;
    logic [5:0]    MEM_ADDRESS;
    logic [127:0]  MEM_READINST;
    logic          MEM_BUSYWAIT;

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READINST (MEM_READINST),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory content: a recognisable word per (block, word) pair.
    function automatic logic [31:0] mem_word(input logic [5:0] blk, input int k);
        return 32'hC000_0000 | (32'(blk) << 8) | 32'(k);
    endfunction

    // Instruction memory model: MEM_READ is noticed one edge late, then the
    // memory stays busy so a fill spends exactly 4 cycles in the read state.
    logic       mem_active;
    logic [1:0] mem_cnt;
    logic [5:0] mem_blk;

    always @(posedge CLK) begin
        if (!RESET) begin
            mem_active   <= 1'b0;
            MEM_BUSYWAIT <= 1'b0;
            mem_cnt      <= '0;
            mem_blk      <= '0;
        end else if (!mem_active) begin
            if (MEM_READ) begin
                mem_active   <= 1'b1;
                MEM_BUSYWAIT <= 1'b1;
                mem_cnt      <= 2'd2;
                mem_blk      <= MEM_ADDRESS;
            end
        end else if (mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
            if (mem_cnt == 1) MEM_BUSYWAIT <= 1'b0;
        end else if (!MEM_READ) begin
            mem_active <= 1'b0;
        end
    end

    always_comb begin
        MEM_READINST = '0;
        for (int k = 0; k < 4; k++) MEM_READINST[32*k +: 32] = mem_word(mem_blk, k);
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb[$];

    // Monitor: an in-range, non-stalled cycle is a delivered instruction.
    always @(negedge CLK) begin
        if (RESET && !BUSYWAIT && PC[31:10] == 0) begin
            if (sb.size() == 0) begin
                check("unexpected_response", PC, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_pc", PC, e.pc);
                check("resp_instr", INSTRUCTION, e.instr);
                check("resp_latency", 32'(cyc - e.issue), 32'(e.lat));
                check("resp_mem_read", {31'b0, MEM_READ}, 32'h0);
            end
        end
    end

    // Present pc at posedge+1; lat = 0 for a hit, 6 for a miss with this memory.
    task automatic fetch(input logic [31:0] pc, input int lat);
        bit done = 0;
        PC = pc;
        sb.push_back('{pc, mem_word(pc[9:4], int'(pc[3:2])), cyc, lat});
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge CLK);
            if (i == 0 && lat != 0) check("miss_busywait", {31'b0, BUSYWAIT}, 32'h1);
            if (i == 1 && lat != 0) begin
                check("miss_mem_read", {31'b0, MEM_READ}, 32'h1);
                check("miss_mem_addr", {26'b0, MEM_ADDRESS}, {26'b0, pc[9:4]});
            end
            if (!BUSYWAIT) done = 1;
        end
        if (!done) check("fetch_timeout", PC, 32'hFFFF_FFFF);
        @(posedge CLK); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busywait"}, {31'b0, BUSYWAIT}, 32'h0);
        check({tag, "_mem_read"}, {31'b0, MEM_READ}, 32'h0);
        check({tag, "_instr"}, INSTRUCTION, 32'h0);
    endtask

    initial begin
        RESET = 1'b1;
        PC    = 32'h0;
        #2 RESET = 1'b0;

        // Reset with an in-range PC: everything quiet.
        @(negedge CLK);
        check_idle_outputs("reset");
        check("reset_mem_addr", {26'b0, MEM_ADDRESS}, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b1;

        // Test 1: cold miss on PC 0, then test 2: consecutive hits in the line.
        fetch(32'h000, 6);
        fetch(32'h004, 0);
        fetch(32'h008, 0);
        fetch(32'h00C, 0);

        // Test 3: conflicting tag on index 0 evicts and re-misses.
        fetch(32'h000, 0);
        fetch(32'h080, 6);
        fetch(32'h084, 0);
        fetch(32'h000, 6);

        // Test 4: out-of-range PC is a non-access.
        PC = 32'hFFFF_FFFC;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check_idle_outputs("oor");
            @(posedge CLK); #1;
        end

        // Test 5: reset in the middle of a fill drops the response.
        PC = 32'h3FC;
        @(negedge CLK);
        check("t5_busywait", {31'b0, BUSYWAIT}, 32'h1);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("t5_mem_read", {31'b0, MEM_READ}, 32'h1);
        check("t5_mem_addr", {26'b0, MEM_ADDRESS}, 32'h3F);
        @(posedge CLK); #1;
        RESET = 1'b0;
        #1;
        check_idle_outputs("t5_rst");
        check("t5_rst_mem_addr", {26'b0, MEM_ADDRESS}, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        fetch(32'h3FC, 6);

        // Test 6: fill every index, then hit each one at a varying offset.
        for (int i = 0; i < 8; i++) fetch(32'(i * 16), 6);
        for (int i = 0; i < 8; i++) fetch(32'(i * 16 + (i % 4) * 4), 0);
        fetch(32'h3F4, 6);

        PC = 32'hFFFF_FFFC;
        repeat (2) @(posedge CLK);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
